// File: rtl/div_pkg.sv
// Shared widths, FSM state encodings and helpers for the sequential restoring divider.
// DIV_SELF_CHECK_EN adds the exact recursive multiplier used for result reconstruction.
package div_pkg;

  localparam int unsigned DIV_DIVIDEND_W = 8;
  localparam int unsigned DIV_DIVISOR_W  = 4;
  localparam int unsigned DIV_CNT_W      = $clog2(DIV_DIVIDEND_W + 1);

  localparam logic [DIV_DIVIDEND_W-1:0] DIV_ZERO_QUOTIENT = '1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef DIV_SELF_CHECK_EN
  // Exact 2x2 base cell built from the partial-product AND array.
  function automatic logic [3:0] mul2x2(input logic [1:0] a, input logic [1:0] b);
    logic p1a, p1b, carry;
    p1a   = a[1] & b[0];
    p1b   = a[0] & b[1];
    carry = p1a & p1b;
    return {a[1] & b[1] & carry, (a[1] & b[1]) ^ carry, p1a ^ p1b, a[0] & b[0]};
  endfunction

  function automatic logic [7:0] mul4x4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] ll, lh, hl, hh;
    ll = mul2x2(a[1:0], b[1:0]);
    lh = mul2x2(a[1:0], b[3:2]);
    hl = mul2x2(a[3:2], b[1:0]);
    hh = mul2x2(a[3:2], b[3:2]);
    return 8'(ll) + (8'(lh) << 2) + (8'(hl) << 2) + (8'(hh) << 4);
  endfunction

  // 8x4 product as two 4x4 halves of the 8-bit operand.
  function automatic logic [11:0] mul8x4(input logic [7:0] a, input logic [3:0] b);
    return (12'(mul4x4(a[7:4], b)) << 4) + 12'(mul4x4(a[3:0], b));
  endfunction
`endif

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
module div_restore_step
  import div_pkg::*;
#(
  parameter int unsigned DIVISOR_W = DIV_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   prem,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   prem_next,
  output logic                 qbit
);

  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] trial;

  assign shifted = {prem[DIVISOR_W-1:0], bit_in};
  assign trial   = shifted - {1'b0, divisor};

  // prem < divisor keeps shifted below 2*divisor, so the trial MSB is a true sign bit.
  assign qbit      = prem[DIVISOR_W] | ~trial[DIVISOR_W];
  assign prem_next = qbit ? trial : shifted;

endmodule

// File: rtl/exact_divider_8by4_seq.sv
// Sequential restoring divider with valid/ready on both sides, one quotient bit per clock.
// Optional DIV_SELF_CHECK_EN adds check_err: quotient*divisor+remainder compared to the dividend.
module exact_divider_8by4_seq
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
`ifdef DIV_SELF_CHECK_EN
  ,
  output logic                  check_err
`endif
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

  logic [1:0]            state, state_nxt;
  logic [CNT_W-1:0]      count, count_nxt;
  logic [DIVIDEND_W-1:0] dvd_sh, dvd_nxt;
  logic [DIVISOR_W-1:0]  dvs, dvs_nxt;
  logic [DIVISOR_W:0]    prem, prem_nxt;
  logic [DIVIDEND_W-1:0] qsh, qsh_nxt;
  logic [DIVIDEND_W-1:0] quotient_nxt;
  logic [DIVISOR_W-1:0]  remainder_nxt;
  logic                  dbz_nxt, out_valid_nxt, in_ready_nxt;
  logic [DIVISOR_W:0]    step_prem;
  logic                  step_q;

  div_restore_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .prem      (prem),
    .bit_in    (dvd_sh[DIVIDEND_W-1]),
    .divisor   (dvs),
    .prem_next (step_prem),
    .qbit      (step_q)
  );

`ifdef DIV_SELF_CHECK_EN
  localparam int unsigned RECON_W = DIVIDEND_W + DIVISOR_W + 1;

  logic [DIVIDEND_W-1:0] dvd_hold, dvd_hold_nxt;
  logic                  check_err_nxt;
  logic [RECON_W-1:0]    recon_c;

  // Reconstruct from the values that will land in the result registers this edge.
  assign recon_c = RECON_W'(mul8x4(qsh_nxt, dvs)) + RECON_W'(step_prem[DIVISOR_W-1:0]);
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    dvd_nxt       = dvd_sh;
    dvs_nxt       = dvs;
    prem_nxt      = prem;
    qsh_nxt       = qsh;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;
    dbz_nxt       = div_by_zero;
    out_valid_nxt = out_valid;
    in_ready_nxt  = in_ready;
`ifdef DIV_SELF_CHECK_EN
    dvd_hold_nxt  = dvd_hold;
    check_err_nxt = check_err;
`endif

    case (state)
      IDLE: begin
        in_ready_nxt = 1'b1;
        if (in_valid && in_ready) begin
          in_ready_nxt = 1'b0;
          dvd_nxt      = dividend;
          dvs_nxt      = divisor;
          prem_nxt     = '0;
          qsh_nxt      = '0;
          count_nxt    = '0;
`ifdef DIV_SELF_CHECK_EN
          dvd_hold_nxt  = dividend;
          check_err_nxt = 1'b0;
`endif
          if (divisor == '0) begin
            state_nxt     = DONE;
            quotient_nxt  = DIVIDEND_W'(DIV_ZERO_QUOTIENT);
            remainder_nxt = '0;
            dbz_nxt       = 1'b1;
          end else begin
            state_nxt = CALC;
          end
        end
      end

      CALC: begin
        in_ready_nxt = 1'b0;
        prem_nxt     = step_prem;
        dvd_nxt      = {dvd_sh[DIVIDEND_W-2:0], 1'b0};
        qsh_nxt      = {qsh[DIVIDEND_W-2:0], step_q};
        count_nxt    = count + CNT_W'(1);
        if (count == CNT_W'(DIVIDEND_W - 1)) begin
          state_nxt     = DONE;
          out_valid_nxt = 1'b1;
          quotient_nxt  = qsh_nxt;
          remainder_nxt = step_prem[DIVISOR_W-1:0];
          dbz_nxt       = 1'b0;
`ifdef DIV_SELF_CHECK_EN
          check_err_nxt = (recon_c != RECON_W'(dvd_hold));
`endif
        end
      end

      DONE: begin
        in_ready_nxt = 1'b0;
        // Divide-by-zero enters DONE without out_valid; raise it one cycle later.
        if (!out_valid) begin
          out_valid_nxt = 1'b1;
        end else if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt     = IDLE;
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      dvd_sh      <= '0;
      dvs         <= '0;
      prem        <= '0;
      qsh         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      dvd_sh      <= dvd_nxt;
      dvs         <= dvs_nxt;
      prem        <= prem_nxt;
      qsh         <= qsh_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
      div_by_zero <= dbz_nxt;
      out_valid   <= out_valid_nxt;
      in_ready    <= in_ready_nxt;
    end
  end

`ifdef DIV_SELF_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_hold  <= '0;
      check_err <= 1'b0;
    end else begin
      dvd_hold  <= dvd_hold_nxt;
      check_err <= check_err_nxt;
    end
  end
`endif

endmodule
